// File: rtl/pcie_130b_pkg.sv
// Shared definitions for the 128b/130b encoder and decoder: sync headers,
// scrambler seed, lock-state encoding and the scrambler LFSR step.
package pcie_130b_pkg;

  localparam logic [1:0]  HDR_POS   = 2'b01;
  localparam logic [1:0]  HDR_NEG   = 2'b10;
  localparam logic [15:0] LFSR_SEED = 16'hFFFF;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] lfsr);
    return {lfsr[14:0], lfsr[15] ^ lfsr[12]};
  endfunction

endpackage

// File: rtl/pcie_130b_lock_fsm.sv
// Block-lock state machine: gains lock on a run of legal headers and drops it
// when too many illegal headers fall within one window of valid words.
module pcie_130b_lock_fsm
  import pcie_130b_pkg::*;
#(
  parameter int LOCK_CNT  = 4,
  parameter int BAD_LIMIT = 8,
  parameter int WIN_LEN   = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic hdr_legal,
  output logic locked
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int WW = $clog2(WIN_LEN + 1);
  localparam int BW = $clog2(BAD_LIMIT + 1);

  localparam logic [GW-1:0] GOOD_TGT = GW'(LOCK_CNT);
  localparam logic [WW-1:0] WIN_TGT  = WW'(WIN_LEN);
  localparam logic [BW-1:0] BAD_TGT  = BW'(BAD_LIMIT);

  lock_state_t   state, state_nxt;
  logic [GW-1:0] good_cnt, good_nxt;
  logic [WW-1:0] win_cnt, win_nxt;
  logic [BW-1:0] bad_cnt, bad_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= UNLOCKED;
      good_cnt <= '0;
      win_cnt  <= '0;
      bad_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      good_cnt <= good_nxt;
      win_cnt  <= win_nxt;
      bad_cnt  <= bad_nxt;
    end
  end

  // Losing lock outranks the window wrap so the last bad word of a window still counts.
  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    win_nxt   = win_cnt;
    bad_nxt   = bad_cnt;
    if (in_valid) begin
      case (state)
        UNLOCKED: begin
          if (hdr_legal) begin
            good_nxt = good_cnt + 1'b1;
            if (good_nxt == GOOD_TGT) begin
              state_nxt = LOCKED;
              win_nxt   = '0;
              bad_nxt   = '0;
            end
          end else begin
            good_nxt = '0;
          end
        end
        LOCKED: begin
          win_nxt = win_cnt + 1'b1;
          if (!hdr_legal) bad_nxt = bad_cnt + 1'b1;
          if (bad_nxt == BAD_TGT) begin
            state_nxt = UNLOCKED;
            good_nxt  = '0;
          end else if (win_nxt == WIN_TGT) begin
            win_nxt = '0;
            bad_nxt = '0;
          end
        end
      endcase
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: rtl/pcie_128b130b_decode.sv
// 128b/130b receive path: header checking, running-disparity prediction,
// payload descrambling and block lock, all outputs registered.
module pcie_128b130b_decode
  import pcie_130b_pkg::*;
#(
  parameter int LOCK_CNT  = 4,
  parameter int BAD_LIMIT = 8,
  parameter int WIN_LEN   = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [129:0] enc_in,
  input  logic         in_valid,
  input  logic         descr_resync,
  output logic [127:0] data_out,
  output logic         out_valid,
  output logic         hdr_err,
  output logic         disp_err,
  output logic         block_lock,
  output logic         rd_out,
  output logic [15:0]  hdr_err_cnt
);

  logic [15:0] lfsr;
  logic        rd_exp;
  logic        locked;
  logic [1:0]  hdr;
  logic [1:0]  exp_hdr;
  logic        hdr_legal;
  logic [7:0]  ones;

  assign hdr       = enc_in[129:128];
  assign hdr_legal = (hdr == HDR_POS) || (hdr == HDR_NEG);
  assign exp_hdr   = rd_exp ? HDR_POS : HDR_NEG;

  always_comb begin
    ones = '0;
    for (int i = 0; i < 128; i++) ones = ones + 8'(enc_in[i]);
  end

  pcie_130b_lock_fsm #(
    .LOCK_CNT (LOCK_CNT),
    .BAD_LIMIT(BAD_LIMIT),
    .WIN_LEN  (WIN_LEN)
  ) u_lock_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .hdr_legal(hdr_legal),
    .locked   (locked)
  );

  // The LFSR advances on every valid word whatever the header, keeping it aligned with the scrambler.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr        <= LFSR_SEED;
      rd_exp      <= 1'b0;
      data_out    <= '0;
      out_valid   <= 1'b0;
      hdr_err     <= 1'b0;
      disp_err    <= 1'b0;
      hdr_err_cnt <= '0;
    end else begin
      out_valid <= 1'b0;
      hdr_err   <= 1'b0;
      disp_err  <= 1'b0;
      if (descr_resync)  lfsr <= LFSR_SEED;
      else if (in_valid) lfsr <= lfsr_step(lfsr);
      if (in_valid) begin
        data_out  <= enc_in[127:0] ^ {8{lfsr}};
        out_valid <= hdr_legal && locked;
        hdr_err   <= !hdr_legal;
        disp_err  <= hdr_legal && (hdr != exp_hdr);
        if (!hdr_legal && (hdr_err_cnt != 16'hFFFF)) hdr_err_cnt <= hdr_err_cnt + 16'd1;
        if (ones > 8'd64)      rd_exp <= 1'b0;
        else if (ones < 8'd64) rd_exp <= 1'b1;
      end
    end
  end

  assign block_lock = locked;
  assign rd_out     = rd_exp;

endmodule

// File: tb/tb_pcie_128b130b_decode.sv
// Directed bench for the 128b/130b decoder: a reference model pushes expected
// outputs per driven cycle into a queue, popped and compared after each edge.
module tb_pcie_128b130b_decode;

  typedef struct {
    logic [127:0] data;
    logic         out_valid;
    logic         hdr_err;
    logic         disp_err;
    logic         block_lock;
    logic         rd_out;
    logic [15:0]  cnt;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [129:0] enc_in = '0;
  logic         in_valid = 1'b0;
  logic         descr_resync = 1'b0;
  logic [127:0] data_out;
  logic         out_valid, hdr_err, disp_err, block_lock, rd_out;
  logic [15:0]  hdr_err_cnt;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  logic [15:0]  m_lfsr;
  logic         m_rd, m_locked;
  int           m_good, m_win, m_bad;
  logic [15:0]  m_cnt;
  logic [127:0] m_data;

  always #5 clk = ~clk;

  pcie_128b130b_decode dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enc_in      (enc_in),
    .in_valid    (in_valid),
    .descr_resync(descr_resync),
    .data_out    (data_out),
    .out_valid   (out_valid),
    .hdr_err     (hdr_err),
    .disp_err    (disp_err),
    .block_lock  (block_lock),
    .rd_out      (rd_out),
    .hdr_err_cnt (hdr_err_cnt)
  );

  task automatic checkField(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_lfsr = 16'hFFFF; m_rd = 1'b0; m_locked = 1'b0;
    m_good = 0; m_win = 0; m_bad = 0; m_cnt = '0; m_data = '0;
  endtask

  task automatic checkAllZero(input string tag);
    checkField({tag, "_data"}, data_out, '0);
    checkField({tag, "_ovld"}, {127'd0, out_valid}, '0);
    checkField({tag, "_herr"}, {127'd0, hdr_err}, '0);
    checkField({tag, "_derr"}, {127'd0, disp_err}, '0);
    checkField({tag, "_lock"}, {127'd0, block_lock}, '0);
    checkField({tag, "_rd"}, {127'd0, rd_out}, '0);
    checkField({tag, "_cnt"}, {112'd0, hdr_err_cnt}, '0);
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++; errors++;
      $error("[TB] FAIL %s scoreboard empty observed=none expected=entry", tag);
      return;
    end
    e = sb.pop_front();
    checkField({tag, "_data"}, data_out, e.data);
    checkField({tag, "_ovld"}, {127'd0, out_valid}, {127'd0, e.out_valid});
    checkField({tag, "_herr"}, {127'd0, hdr_err}, {127'd0, e.hdr_err});
    checkField({tag, "_derr"}, {127'd0, disp_err}, {127'd0, e.disp_err});
    checkField({tag, "_lock"}, {127'd0, block_lock}, {127'd0, e.block_lock});
    checkField({tag, "_rd"}, {127'd0, rd_out}, {127'd0, e.rd_out});
    checkField({tag, "_cnt"}, {112'd0, hdr_err_cnt}, {112'd0, e.cnt});
  endtask

  // Drive one cycle (valid word or idle), predict its registered outputs, then check them.
  task automatic applyStimulus(input string tag, input logic vld, input logic [1:0] hdr,
                               input logic [127:0] payload, input logic resync);
    exp_t e;
    logic legal;
    enc_in       = {hdr, payload};
    in_valid     = vld;
    descr_resync = resync;
    legal = (hdr == 2'b01) || (hdr == 2'b10);
    e.out_valid = 1'b0; e.hdr_err = 1'b0; e.disp_err = 1'b0;
    if (vld) begin
      m_data      = payload ^ {8{m_lfsr}};
      e.out_valid = legal && m_locked;
      e.hdr_err   = !legal;
      e.disp_err  = legal && (hdr != (m_rd ? 2'b01 : 2'b10));
      if (!legal && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      m_lfsr = resync ? 16'hFFFF : {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[12]};
      if ($countones(payload) > 64) m_rd = 1'b0;
      else if ($countones(payload) < 64) m_rd = 1'b1;
      if (!m_locked) begin
        if (legal) begin
          m_good++;
          if (m_good == 4) begin m_locked = 1'b1; m_win = 0; m_bad = 0; end
        end else m_good = 0;
      end else begin
        m_win++;
        if (!legal) m_bad++;
        if (m_bad == 8) begin m_locked = 1'b0; m_good = 0; end
        else if (m_win == 64) begin m_win = 0; m_bad = 0; end
      end
    end else if (resync) begin
      m_lfsr = 16'hFFFF;
    end
    e.data = m_data; e.block_lock = m_locked; e.rd_out = m_rd; e.cnt = m_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic goodWord(input string tag);
    applyStimulus(tag, 1'b1, m_rd ? 2'b01 : 2'b10, rnd128(), 1'b0);
  endtask

  task automatic badWord(input string tag);
    applyStimulus(tag, 1'b1, 2'b11, rnd128(), 1'b0);
  endtask

  task automatic doReset(input string tag);
    #2 rst_n = 1'b0;
    #1 checkAllZero(tag);
    modelReset();
    sb.delete();
    in_valid = 1'b0; descr_resync = 1'b0;
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    logic [127:0] x;
    modelReset();
    doReset("rst0");

    applyStimulus("first", 1'b1, 2'b10, {128{1'b1}}, 1'b0);
    checkField("first_data0", data_out, '0);

    doReset("rst1");
    for (int i = 0; i < 4; i++) goodWord("acq");
    checkField("lock_after_4", {127'd0, block_lock}, 128'd1);
    goodWord("fifth");
    checkField("ovld_fifth", {127'd0, out_valid}, 128'd1);
    applyStimulus("idle", 1'b0, 2'b00, '0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      goodWord("mix_good");
      badWord("mix_bad");
    end
    checkField("lock_lost", {127'd0, block_lock}, 128'd0);
    checkField("herr_cnt8", {112'd0, hdr_err_cnt}, 128'd8);

    for (int i = 0; i < 4; i++) goodWord("relock");
    for (int i = 0; i < 7; i++) applyStimulus("win_bad_a", 1'b1, 2'b00, rnd128(), 1'b0);
    for (int i = 0; i < 57; i++) goodWord("win_good");
    for (int i = 0; i < 7; i++) badWord("win_bad_b");
    checkField("lock_kept", {127'd0, block_lock}, 128'd1);

    applyStimulus("rd_to0", 1'b1, m_rd ? 2'b01 : 2'b10, {128{1'b1}}, 1'b0);
    applyStimulus("disp", 1'b1, 2'b01, '0, 1'b0);
    checkField("disp_err1", {127'd0, disp_err}, 128'd1);
    checkField("disp_herr0", {127'd0, hdr_err}, 128'd0);
    checkField("disp_rd1", {127'd0, rd_out}, 128'd1);

    goodWord("resync_word");
    applyStimulus("resync", 1'b1, m_rd ? 2'b01 : 2'b10, rnd128(), 1'b1);
    x = rnd128();
    applyStimulus("post_resync", 1'b1, m_rd ? 2'b01 : 2'b10, x ^ {8{16'hFFFF}}, 1'b0);
    checkField("resync_data", data_out, x);
    applyStimulus("idle2", 1'b0, 2'b10, rnd128(), 1'b0);

    checkField("pre_rst_lock", {127'd0, block_lock}, 128'd1);
    doReset("rst_mid");
    goodWord("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pcie_128b130b_decode.md
PCIE_128B130B_DECODE -- requirements
Module: pcie_128b130b_decode

Interface
REQ-001 The module SHALL have parameter LOCK_CNT, default 4: consecutive legal headers required to gain block lock.
REQ-002 The module SHALL have parameter BAD_LIMIT, default 8: illegal headers within one window that cause loss of lock.
REQ-003 The module SHALL have parameter WIN_LEN, default 64: bad-header window length, in valid words.
REQ-004 The module SHALL have port clk, input, 1 bit: clock.
REQ-005 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The module SHALL have port enc_in, input, 130 bits: received word; [129:128] sync header, [127:0] scrambled payload.
REQ-007 The module SHALL have port in_valid, input, 1 bit: enc_in valid this cycle.
REQ-008 The module SHALL have port descr_resync, input, 1 bit: synchronous pulse that re-seeds the descrambler LFSR.
REQ-009 The module SHALL have port data_out, output, 128 bits: descrambled payload.
REQ-010 The module SHALL have port out_valid, output, 1 bit: data_out valid.
REQ-011 The module SHALL have port hdr_err, output, 1 bit: one-cycle pulse for an illegal header (00 or 11).
REQ-012 The module SHALL have port disp_err, output, 1 bit: one-cycle pulse when a legal header does not match the predicted disparity.
REQ-013 The module SHALL have port block_lock, output, 1 bit: lock FSM is in LOCKED.
REQ-014 The module SHALL have port rd_out, output, 1 bit: predicted running disparity (debug).
REQ-015 The module SHALL have port hdr_err_cnt, output, 16 bits: saturating count of illegal headers.

Function
REQ-016 The descrambler LFSR SHALL be 16 bits, seeded 16'hFFFF, and on each in_valid step to {lfsr[14:0], lfsr[15]^lfsr[12]}, regardless of lock state or header legality.
REQ-017 The payload SHALL be descrambled as enc_in[127:0] XOR {8{lfsr}}, using the LFSR value before that cycle's step.
REQ-018 When descr_resync and in_valid are both high, the current word SHALL use the pre-step LFSR value, and the LFSR SHALL load 16'hFFFF instead of stepping.
REQ-019 Legal headers SHALL be 2'b01 (rd=1) and 2'b10 (rd=0).
REQ-020 The predicted disparity rd_exp SHALL reset to 0; on each in_valid, expected header = rd_exp ? 01 : 10.
REQ-021 After each in_valid, rd_exp SHALL become 0 if popcount(enc_in[127:0]) > 64, 1 if < 64, and hold if == 64.
REQ-022 The rd_exp update SHALL occur on every valid word, including words with an illegal header.
REQ-023 disp_err SHALL pulse only for a legal header that does not equal the expected header; disp_err and hdr_err SHALL never both be high.
REQ-024 The lock FSM SHALL have states UNLOCKED and LOCKED, with reset state UNLOCKED.
REQ-025 In UNLOCKED: a legal header SHALL increment good_cnt; an illegal header SHALL clear good_cnt; the FSM SHALL move to LOCKED on the word that makes good_cnt == LOCK_CNT.
REQ-026 On entering LOCKED, win_cnt and bad_cnt SHALL clear.
REQ-027 In LOCKED: each valid word SHALL increment win_cnt; an illegal header SHALL increment bad_cnt.
REQ-028 In LOCKED, when bad_cnt reaches BAD_LIMIT, the FSM SHALL go to UNLOCKED and clear good_cnt; this check SHALL take priority over the window wrap.
REQ-029 In LOCKED, when win_cnt wraps at WIN_LEN, win_cnt and bad_cnt SHALL clear.
REQ-030 The lock FSM SHALL not change on cycles without in_valid.
REQ-031 All outputs SHALL be registered with 1-cycle latency from in_valid.
REQ-032 out_valid SHALL equal in_valid & header legal & (FSM state before the update == LOCKED).
REQ-033 data_out SHALL update on every in_valid and hold otherwise.
REQ-034 hdr_err_cnt SHALL increment on each illegal header and saturate at 16'hFFFF.

Reset
REQ-035 On rst_n low, the module SHALL immediately set lfsr=16'hFFFF, rd_exp=0, FSM=UNLOCKED, all counters=0, data_out=0, and out_valid=hdr_err=disp_err=block_lock=0; reset mid-stream SHALL discard all lock and disparity history.

Structure
REQ-036 Package pcie_130b_pkg SHALL hold HDR_POS=2'b01, HDR_NEG=2'b10, LFSR_SEED=16'hFFFF, the lock-state enum, and an lfsr_step function shared with the encoder.
REQ-037 Sub-module pcie_130b_lock_fsm SHALL implement the lock FSM and its good/win/bad counters.

Verification
REQ-038 Reset, then send {2'b10, 128{1'b1}} -> data_out=0, disp_err=0, rd_out=0, out_valid=0 (still unlocked).
REQ-039 Send 4 legal, disparity-consistent words -> block_lock=1 one cycle after the 4th word; out_valid=1 from the 5th word.
REQ-040 While locked, send 8 headers of 2'b11 within 64 words -> hdr_err pulses 8 times, block_lock drops after the 8th, hdr_err_cnt=8.
REQ-041 While locked, send 7 bad headers, then 57 good words, then 7 bad headers -> block_lock stays 1 (window cleared).
REQ-042 Send a legal 01 header when rd_exp=0 -> disp_err=1, hdr_err=0, and rd_exp still updates from the payload popcount.
REQ-043 Pulse descr_resync alongside the encoder reset mid-stream -> next payload descrambles correctly; assert rst_n low mid-lock -> all outputs 0 asynchronously.
